grf_wb_arbiter: RTL and testbench
=================================

# grf_wb_arbiter

Write-port arbiter for the general register file. It merges the pipeline W-stage writeback with results from a long-latency unit (MDU or similar) onto the GRF's single write port. Long-unit results wait in a small ordered buffer whose pending contents can be queried for forwarding. It sits between the W stage / long unit and the GRF write inputs (write enable, destination address, write data).

## Interface
- DEPTH, 2, buffer entries; power of two, at least 2
- AW, 5, register address width
- DW, 32, data width

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low (0 = reset)
- P_we  input  1  pipeline writeback request; no backpressure
- P_a3  input  AW  pipeline destination register
- P_wd  input  DW  pipeline write data
- L_valid  input  1  long-unit result valid
- L_ready  output  1  buffer can accept a long-unit result
- L_a3  input  AW  long-unit destination register
- L_wd  input  DW  long-unit data
- G_we  output  1  GRF write enable
- G_a3  output  AW  GRF write address
- G_wd  output  DW  GRF write data
- Q_a1, Q_a2  input  AW  query addresses, driven from the D-stage read addresses
- Q_hit1, Q_hit2  output  1  a live buffered write targets Q_aN
- Q_fwd1, Q_fwd2  output  DW  data of the youngest live match for Q_aN; 0 when there is no hit
- busy  output  1  buffer non-empty

## Operation
- Buffer: circular FIFO of DEPTH entries. Each entry holds {live, a3, wd}.
- Accept: an L handshake is L_valid && L_ready. L_ready = (count < DEPTH). L_ready never depends on a same-cycle pop.
- An accepted L result with L_a3 == 0 completes the handshake but is not enqueued.
- Port grant (combinational), in priority order:
  - If P_we && P_a3 != 0: G = {1, P_a3, P_wd}. The buffer does not pop.
  - Else if the buffer is non-empty: pop the head. G = {head.live, head.a3, head.wd}. A dead head pops with G_we = 0.
  - Else: G_we = 0, G_a3 = 0, G_wd = 0.
- P_we with P_a3 == 0 is treated as no request.
- Cancel rule: a granted P write is younger than every buffered entry. At that clock edge, every entry with a3 == P_a3 has live cleared.
- Same-cycle L accept with L_a3 == P_a3: the new entry is younger than the P write and stays live.
- Push and pop in the same cycle: count is unchanged.
- Query: Q_hitN = 1 if any live entry has a3 == Q_aN and Q_aN != 0. Q_fwdN comes from the youngest such entry. Query logic is combinational from buffer state only; same-cycle P/L inputs are not included.

## Timing
- Reset (reset = 0), effective immediately:
  - buffer emptied, count = 0
  - G_we = 0, G_a3 = 0, G_wd = 0
  - L_ready = 0, busy = 0, all Q_hit = 0, all Q_fwd = 0
- First cycle after reset release: L_ready = 1.
- P path: zero latency, purely combinational from P_* to G_*.
- L path: an entry accepted at edge k can reach G no earlier than the cycle after edge k. With continuous P writes, the wait is unbounded; this is by design, since the pipeline stalls on Q_hit.
- Full: L_ready = 0 while count == DEPTH. L_valid and L payload must be held stable until accepted.
- Pointer wrap: read and write pointers wrap modulo DEPTH. count distinguishes full from empty.
- Reset assertion mid-operation discards all entries. No buffered write may reach G after release.

## Structure
- Shared package/header grf_wb_defs holds:
  - AW, DW, DEPTH defaults
  - the entry record {live, a3, wd}
  - the zero-register constant
- Sub-module grf_wb_fifo: circular buffer with push, pop, per-entry cancel-by-address, and a two-port youngest-match CAM query.
- The top level holds grant muxing, the $0 filter, and L_ready.

## Test plan
- Reset mid-operation: fill 2 entries {4,0x10},{6,0x20}, then pull reset low -> busy = 0, L_ready = 0, G_we = 0 at once. After release: L_ready = 1, and G_we stays 0 for 4 idle cycles.
- L only: L_valid, L_a3 = 8, L_wd = 0x1234 accepted at edge 0 -> cycle 1 shows G_we = 1, G_a3 = 8, G_wd = 0x1234 and Q_a1 = 8 gives hit, fwd 0x1234. After edge 1: busy = 0, hit = 0.
- P priority: buffer holds {9,0xAA}; P_we with a3 = 3, wd = 0x55 for 2 cycles -> G shows 3/0x55 both cycles and Q_a2 = 9 hits with 0xAA. Third cycle: G shows 9/0xAA.
- Full/backpressure (DEPTH = 2): P_we held high, push {1,0x1},{2,0x2} -> L_ready = 0 and a third L_valid is held. Drop P_we -> pops in order 1, 2, and the third entry is accepted after the first pop.
- Cancel and same-cycle collision: buffer {5,0x11}; P_we a3 = 5, wd = 0x22 together with L accept {5,0x33} -> G shows 5/0x22. Next cycle: dead head pops with G_we = 0 and Q_a1 = 5 gives 0x33. Following cycle: G writes 5/0x33.
- Register $0: L {0,0xFF} handshakes but busy stays 0; P_we with a3 = 0 gives G_we = 0; Q_a1 = 0 never hits.

Source files
------------

// File: rtl/grf_wb_arbiter_pkg.sv
// grf_wb_defs: shared definitions for the GRF write-port arbiter.
//   AW_DEF / DW_DEF / DEPTH_DEF : default address width, data width, buffer depth
//   ZERO_REG                    : architectural $0, never written and never forwarded
//   grf_wb_entry_t              : buffered write record {live, a3, wd} at default widths;
//                                 parameterised modules re-declare the same layout
//                                 at their own widths.
package grf_wb_defs;

  localparam int AW_DEF    = 5;
  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 2;
  localparam int ZERO_REG  = 0;

  typedef struct packed {
    logic              live;
    logic [AW_DEF-1:0] a3;
    logic [DW_DEF-1:0] wd;
  } grf_wb_entry_t;

endpackage

// File: rtl/grf_wb_arbiter_fifo.sv
// grf_wb_fifo: ordered circular buffer of pending long-unit register writes.
//   clk, reset          : clock, asynchronous active-low reset
//   push/push_a3/push_wd: enqueue a live entry at the tail
//   pop                 : drop the head (caller guarantees non-empty)
//   cancel/cancel_a3    : clear live on every stored entry targeting cancel_a3
//   head_*              : current head entry
//   count               : number of occupied slots (0..DEPTH)
//   q_aN -> q_hitN/q_fwdN : youngest live match for each query address
module grf_wb_fifo
  import grf_wb_defs::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int AW    = AW_DEF,
  parameter  int DW    = DW_DEF,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_a3,
  input  logic [DW-1:0] push_wd,
  input  logic          pop,
  input  logic          cancel,
  input  logic [AW-1:0] cancel_a3,
  input  logic [AW-1:0] q_a1,
  input  logic [AW-1:0] q_a2,
  output logic          head_live,
  output logic [AW-1:0] head_a3,
  output logic [DW-1:0] head_wd,
  output logic [PW:0]   count,
  output logic          q_hit1,
  output logic [DW-1:0] q_fwd1,
  output logic          q_hit2,
  output logic [DW-1:0] q_fwd2
);

  logic          live_q [DEPTH];
  logic [AW-1:0] a3_q   [DEPTH];
  logic [DW-1:0] wd_q   [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [PW:0]   cnt_q;
  logic [PW-1:0] idx;

  // Slots outside the occupied range always have live = 0 (cleared on pop and
  // reset), so the query only needs to scan live bits, not the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        live_q[i] <= 1'b0;
        a3_q[i]   <= '0;
        wd_q[i]   <= '0;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cancel && live_q[i] && (a3_q[i] == cancel_a3)) live_q[i] <= 1'b0;
      end
      if (pop) begin
        live_q[rd_q] <= 1'b0;
        rd_q         <= rd_q + PW'(1);
      end
      // Push after cancel: a same-cycle entry is younger than the cancelling
      // write and must stay live.
      if (push) begin
        live_q[wr_q] <= 1'b1;
        a3_q[wr_q]   <= push_a3;
        wd_q[wr_q]   <= push_wd;
        wr_q         <= wr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_live = live_q[rd_q];
  assign head_a3   = a3_q[rd_q];
  assign head_wd   = wd_q[rd_q];
  assign count     = cnt_q;

  // Scan oldest to youngest; later matches overwrite earlier ones.
  always_comb begin
    q_hit1 = 1'b0;
    q_fwd1 = '0;
    q_hit2 = 1'b0;
    q_fwd2 = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_q + PW'(i);
      if (live_q[idx] && (a3_q[idx] == q_a1) && (q_a1 != AW'(ZERO_REG))) begin
        q_hit1 = 1'b1;
        q_fwd1 = wd_q[idx];
      end
      if (live_q[idx] && (a3_q[idx] == q_a2) && (q_a2 != AW'(ZERO_REG))) begin
        q_hit2 = 1'b1;
        q_fwd2 = wd_q[idx];
      end
    end
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: merges pipeline W-stage writeback and long-unit results onto
// the single GRF write port.
//   clk, reset              : clock, asynchronous active-low reset
//   P_we/P_a3/P_wd          : pipeline writeback (no backpressure, highest priority)
//   L_valid/L_ready/L_a3/L_wd : long-unit result handshake
//   G_we/G_a3/G_wd          : GRF write port
//   Q_a1/Q_a2 -> Q_hitN/Q_fwdN : forwarding query against pending buffered writes
//   busy                    : buffer non-empty
//
// Handshake: an L result transfers on a rising edge where L_valid && L_ready.
// L_ready depends only on buffer occupancy (never on a same-cycle pop); the
// producer holds L_valid and payload stable until the transfer. A transfer
// to $0 completes but stores nothing.
module grf_wb_arbiter
  import grf_wb_defs::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int AW    = AW_DEF,
  parameter  int DW    = DW_DEF,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          P_we,
  input  logic [AW-1:0] P_a3,
  input  logic [DW-1:0] P_wd,
  input  logic          L_valid,
  output logic          L_ready,
  input  logic [AW-1:0] L_a3,
  input  logic [DW-1:0] L_wd,
  output logic          G_we,
  output logic [AW-1:0] G_a3,
  output logic [DW-1:0] G_wd,
  input  logic [AW-1:0] Q_a1,
  input  logic [AW-1:0] Q_a2,
  output logic          Q_hit1,
  output logic          Q_hit2,
  output logic [DW-1:0] Q_fwd1,
  output logic [DW-1:0] Q_fwd2,
  output logic          busy
);

  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

  logic          p_req;
  logic          non_empty;
  logic          push;
  logic          pop;
  logic          head_live;
  logic [AW-1:0] head_a3;
  logic [DW-1:0] head_wd;
  logic [PW:0]   count;

  assign p_req     = P_we && (P_a3 != AW'(ZERO_REG));
  assign non_empty = (count != '0);
  // Gated by reset so the port reads "not ready" while held in reset.
  assign L_ready   = reset && (count < DEPTH_CNT);
  assign push      = L_valid && L_ready && (L_a3 != AW'(ZERO_REG));
  assign pop       = reset && !p_req && non_empty;
  assign busy      = non_empty;

  always_comb begin
    G_we = 1'b0;
    G_a3 = '0;
    G_wd = '0;
    if (reset) begin
      if (p_req) begin
        G_we = 1'b1;
        G_a3 = P_a3;
        G_wd = P_wd;
      end else if (non_empty) begin
        // A cancelled head still drains, just without a write.
        G_we = head_live;
        G_a3 = head_a3;
        G_wd = head_wd;
      end
    end
  end

  grf_wb_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_a3  (L_a3),
    .push_wd  (L_wd),
    .pop      (pop),
    .cancel   (p_req),
    .cancel_a3(P_a3),
    .q_a1     (Q_a1),
    .q_a2     (Q_a2),
    .head_live(head_live),
    .head_a3  (head_a3),
    .head_wd  (head_wd),
    .count    (count),
    .q_hit1   (Q_hit1),
    .q_fwd1   (Q_fwd1),
    .q_hit2   (Q_hit2),
    .q_fwd2   (Q_fwd2)
  );

endmodule

// File: tb/tb_grf_wb_arbiter.sv
module tb_grf_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        P_we;
  logic [4:0]  P_a3;
  logic [31:0] P_wd;
  logic        L_valid;
  logic        L_ready;
  logic [4:0]  L_a3;
  logic [31:0] L_wd;
  logic        G_we;
  logic [4:0]  G_a3;
  logic [31:0] G_wd;
  logic [4:0]  Q_a1, Q_a2;
  logic        Q_hit1, Q_hit2;
  logic [31:0] Q_fwd1, Q_fwd2;
  logic        busy;

  int checks = 0;
  int errors = 0;

  grf_wb_arbiter #(.DEPTH(2), .AW(5), .DW(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .P_we   (P_we),
    .P_a3   (P_a3),
    .P_wd   (P_wd),
    .L_valid(L_valid),
    .L_ready(L_ready),
    .L_a3   (L_a3),
    .L_wd   (L_wd),
    .G_we   (G_we),
    .G_a3   (G_a3),
    .G_wd   (G_wd),
    .Q_a1   (Q_a1),
    .Q_a2   (Q_a2),
    .Q_hit1 (Q_hit1),
    .Q_hit2 (Q_hit2),
    .Q_fwd1 (Q_fwd1),
    .Q_fwd2 (Q_fwd2),
    .busy   (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        p_we;
    logic [4:0]  p_a3;
    logic [31:0] p_wd;
    logic        l_valid;
    logic [4:0]  l_a3;
    logic [31:0] l_wd;
    logic [4:0]  q_a1;
    logic [4:0]  q_a2;
    logic        g_we;
    logic [4:0]  g_a3;
    logic [31:0] g_wd;
    logic        l_ready;
    logic        busy;
    logic        hit1;
    logic [31:0] fwd1;
    logic        hit2;
    logic [31:0] fwd2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic p_we, input logic [4:0] p_a3, input logic [31:0] p_wd,
    input logic l_valid, input logic [4:0] l_a3, input logic [31:0] l_wd,
    input logic [4:0] q_a1, input logic [4:0] q_a2,
    input logic g_we, input logic [4:0] g_a3, input logic [31:0] g_wd,
    input logic l_ready, input logic bsy,
    input logic hit1, input logic [31:0] fwd1,
    input logic hit2, input logic [31:0] fwd2);
    vec_t v;
    v.p_we = p_we;   v.p_a3 = p_a3;   v.p_wd = p_wd;
    v.l_valid = l_valid; v.l_a3 = l_a3; v.l_wd = l_wd;
    v.q_a1 = q_a1;   v.q_a2 = q_a2;
    v.g_we = g_we;   v.g_a3 = g_a3;   v.g_wd = g_wd;
    v.l_ready = l_ready; v.busy = bsy;
    v.hit1 = hit1;   v.fwd1 = fwd1;   v.hit2 = hit2; v.fwd2 = fwd2;
    return v;
  endfunction

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // driver: drive on negedge, sample 1ns later (well before the next posedge)
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    P_we = v.p_we; P_a3 = v.p_a3; P_wd = v.p_wd;
    L_valid = v.l_valid; L_a3 = v.l_a3; L_wd = v.l_wd;
    Q_a1 = v.q_a1; Q_a2 = v.q_a2;
    #1;
    check({tag, ".G_we"},    32'(G_we),    32'(v.g_we));
    check({tag, ".G_a3"},    32'(G_a3),    32'(v.g_a3));
    check({tag, ".G_wd"},    G_wd,         v.g_wd);
    check({tag, ".L_ready"}, 32'(L_ready), 32'(v.l_ready));
    check({tag, ".busy"},    32'(busy),    32'(v.busy));
    check({tag, ".Q_hit1"},  32'(Q_hit1),  32'(v.hit1));
    check({tag, ".Q_fwd1"},  Q_fwd1,       v.fwd1);
    check({tag, ".Q_hit2"},  32'(Q_hit2),  32'(v.hit2));
    check({tag, ".Q_fwd2"},  Q_fwd2,       v.fwd2);
  endtask

  task automatic drive_idle();
    P_we = 1'b0; P_a3 = '0; P_wd = '0;
    L_valid = 1'b0; L_a3 = '0; L_wd = '0;
    Q_a1 = '0; Q_a2 = '0;
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();

    //        P we a3  wd     L v a3  wd        q1  q2   G we a3 wd        rdy bsy h1 f1        h2 f2
    // L only
    vecs.push_back(mk(0, 0, 0,     1, 8, 32'h1234, 8, 0,  0, 0, 0,         1, 0, 0, 0,        0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,        8, 0,  1, 8, 32'h1234,  1, 1, 1, 32'h1234, 0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,        8, 0,  0, 0, 0,         1, 0, 0, 0,        0, 0));
    // P priority
    vecs.push_back(mk(0, 0, 0,     1, 9, 32'hAA,   0, 0,  0, 0, 0,         1, 0, 0, 0,        0, 0));
    vecs.push_back(mk(1, 3, 32'h55, 0, 0, 0,       0, 9,  1, 3, 32'h55,    1, 1, 0, 0,        1, 32'hAA));
    vecs.push_back(mk(1, 3, 32'h55, 0, 0, 0,       0, 9,  1, 3, 32'h55,    1, 1, 0, 0,        1, 32'hAA));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,        0, 9,  1, 9, 32'hAA,    1, 1, 0, 0,        1, 32'hAA));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,        0, 9,  0, 0, 0,         1, 0, 0, 0,        0, 0));
    // Full / backpressure
    vecs.push_back(mk(1, 30, 32'h77, 1, 1, 32'h1,  0, 0,  1, 30, 32'h77,   1, 0, 0, 0,        0, 0));
    vecs.push_back(mk(1, 30, 32'h77, 1, 2, 32'h2,  0, 0,  1, 30, 32'h77,   1, 1, 0, 0,        0, 0));
    vecs.push_back(mk(1, 30, 32'h77, 1, 3, 32'h3,  1, 2,  1, 30, 32'h77,   0, 1, 1, 32'h1,    1, 32'h2));
    vecs.push_back(mk(0, 0, 0,     1, 3, 32'h3,    0, 0,  1, 1, 32'h1,     0, 1, 0, 0,        0, 0));
    vecs.push_back(mk(0, 0, 0,     1, 3, 32'h3,    0, 0,  1, 2, 32'h2,     1, 1, 0, 0,        0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,        3, 0,  1, 3, 32'h3,     1, 1, 1, 32'h3,    0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,        0, 0,  0, 0, 0,         1, 0, 0, 0,        0, 0));
    // Cancel and same-cycle collision
    vecs.push_back(mk(0, 0, 0,     1, 5, 32'h11,   0, 0,  0, 0, 0,         1, 0, 0, 0,        0, 0));
    vecs.push_back(mk(1, 5, 32'h22, 1, 5, 32'h33,  5, 0,  1, 5, 32'h22,    1, 1, 1, 32'h11,   0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,        5, 0,  0, 5, 32'h11,    0, 1, 1, 32'h33,   0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,        5, 0,  1, 5, 32'h33,    1, 1, 1, 32'h33,   0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,        5, 0,  0, 0, 0,         1, 0, 0, 0,        0, 0));
    // Register $0
    vecs.push_back(mk(0, 0, 0,     1, 0, 32'hFF,   0, 0,  0, 0, 0,         1, 0, 0, 0,        0, 0));
    vecs.push_back(mk(1, 0, 32'h99, 0, 0, 0,       0, 0,  0, 0, 0,         1, 0, 0, 0,        0, 0));
    vecs.push_back(mk(0, 0, 0,     1, 7, 32'h70,   0, 0,  0, 0, 0,         1, 0, 0, 0,        0, 0));
    vecs.push_back(mk(1, 0, 32'h99, 0, 0, 0,       0, 7,  1, 7, 32'h70,    1, 1, 0, 0,        1, 32'h70));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,        0, 0,  0, 0, 0,         1, 0, 0, 0,        0, 0));
    // Youngest-match forwarding with two entries to the same register
    vecs.push_back(mk(1, 20, 32'h1, 1, 4, 32'h41,  4, 0,  1, 20, 32'h1,    1, 0, 0, 0,        0, 0));
    vecs.push_back(mk(1, 20, 32'h1, 1, 4, 32'h42,  4, 0,  1, 20, 32'h1,    1, 1, 1, 32'h41,   0, 0));
    vecs.push_back(mk(1, 20, 32'h1, 0, 0, 0,       4, 0,  1, 20, 32'h1,    0, 1, 1, 32'h42,   0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,        4, 0,  1, 4, 32'h41,    0, 1, 1, 32'h42,   0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,        4, 0,  1, 4, 32'h42,    1, 1, 1, 32'h42,   0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,        4, 0,  0, 0, 0,         1, 0, 0, 0,        0, 0));

    // Reset state, with P_we driven to confirm the port is held quiet
    #2;
    P_we = 1'b1; P_a3 = 5'd3; P_wd = 32'h5;
    #1;
    check("rst.G_we",    32'(G_we),    32'd0);
    check("rst.L_ready", 32'(L_ready), 32'd0);
    check("rst.busy",    32'(busy),    32'd0);
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_rst.L_ready", 32'(L_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset mid-operation: fill {4,0x10},{6,0x20} while P blocks the pops
    apply(mk(1, 21, 32'h0, 1, 4, 32'h10, 0, 0, 1, 21, 32'h0, 1, 0, 0, 0, 0, 0), "fill0");
    apply(mk(1, 21, 32'h0, 1, 6, 32'h20, 4, 6, 1, 21, 32'h0, 1, 1, 1, 32'h10, 0, 0), "fill1");
    @(negedge clk);
    P_we = 1'b1; P_a3 = 5'd21; L_valid = 1'b0; Q_a1 = 5'd4; Q_a2 = 5'd6;
    #1;
    check("mid.full_busy",    32'(busy),    32'd1);
    check("mid.full_L_ready", 32'(L_ready), 32'd0);
    check("mid.full_hit2",    32'(Q_hit2),  32'd1);
    reset = 1'b0;
    #1;
    check("mid.rst_busy",    32'(busy),    32'd0);
    check("mid.rst_L_ready", 32'(L_ready), 32'd0);
    check("mid.rst_G_we",    32'(G_we),    32'd0);
    check("mid.rst_hit1",    32'(Q_hit1),  32'd0);
    check("mid.rst_hit2",    32'(Q_hit2),  32'd0);
    check("mid.rst_fwd2",    Q_fwd2,       32'd0);
    @(negedge clk);
    drive_idle();
    Q_a1 = 5'd4; Q_a2 = 5'd6;
    reset = 1'b1;
    #1;
    check("mid.rel_L_ready", 32'(L_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("mid.idle%0d_G_we", c), 32'(G_we), 32'd0);
      check($sformatf("mid.idle%0d_busy", c), 32'(busy), 32'd0);
      check($sformatf("mid.idle%0d_hit1", c), 32'(Q_hit1), 32'd0);
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
